retire_queue: RTL
=================

// Module: retire_queue
// PURPOSE
//  Parametrised in-order retire buffer between the memory stage and architectural commit.
//  Absorbs up to DEPTH completed instructions. Drains one per cycle, when permitted, into the regfile write port and the commit-trace outputs.
//  Exposes a register-lookup port so decode can forward from not-yet-committed results.
//  Keeps retired-instruction and cycle counters; optionally detects the halt trap.
// PARAMETERS
//  DEPTH     4   queue entries; power of two, >=2
//  XLEN      64  data/pc/addr width
//  MMIO_BIT  31  addr bit; mem op with this bit ==0 is MMIO -> commit_skip
// PORTS
//  clk            in   1     clock
//  reset          in   1     asynchronous, active-high reset
//  in_valid       in   1     retire record offered
//  in_ready       out  1     queue can accept (count<DEPTH and not halted)
//  in_pc          in   XLEN  pc of record
//  in_instr       in   32    raw instruction
//  in_regwrite    in   1     record writes rd
//  in_dst         in   5     rd
//  in_result      in   XLEN  rd value
//  in_is_mem      in   1     load/store
//  in_addr        in   XLEN  effective address (valid when in_is_mem)
//  drain_en       in   1     commit permitted this cycle
//  wvalid         out  1     regfile write enable
//  wa             out  5     regfile write address
//  wd             out  XLEN  regfile write data
//  commit_valid   out  1     head retires this cycle
//  commit_pc      out  XLEN  head pc
//  commit_instr   out  32    head raw instruction
//  commit_skip    out  1     head is MMIO access
//  commit_wen     out  1     head regwrite
//  commit_wdest   out  8     {3'b0,head dst}
//  commit_wdata   out  XLEN  head result
//  lk_addr        in   5     forwarding lookup register
//  lk_hit         out  1     a queued entry writes lk_addr
//  lk_data        out  XLEN  youngest matching queued result
//  instr_cnt      out  64    retired-instruction count
//  cycle_cnt      out  64    cycles since reset
//  trap_valid     out  1     halt retired (COMMIT_TRAP_EN only, else tied 0)
//  trap_code      out  3     shadow x10[2:0] at halt (COMMIT_TRAP_EN only, else 0)
// BEHAVIOUR
//  - Reset (async): head/tail/count=0; shadow x10=0; halted=0; counters=0.
//    All commit/w*/lk_* outputs =0 while empty; in_ready=1 after reset deasserts.
//  - Enqueue: in_valid&&in_ready at edge t -> entry is visible at head/lookup from t+1.
//    No same-cycle bypass input->commit.
//  - in_ready = (count!=DEPTH) && !halted. It is combinational from state only and does not depend on drain_en.
//  - Commit: commit_valid = (count!=0) && drain_en. Outputs are driven combinationally from the head entry.
//    Head pops at that edge. Exactly one retire per cycle maximum.
//  - wvalid = commit_valid && commit_wen && dst!=0; wa=dst; wd=result.
//  - commit_skip = is_mem && addr[MMIO_BIT]==0.
//  - Simultaneous enq+deq: count unchanged, both pointers advance.
//    Full + drain: in_ready stays 0 that cycle. Pointers wrap mod DEPTH.
//  - Lookup: lk_addr==0 -> lk_hit=0. Otherwise scan valid entries tail-1 down to head.
//    The first entry with regwrite && dst==lk_addr wins. The head entry is included even while committing.
//  - instr_cnt += commit_valid each cycle; cycle_cnt +=1 every cycle out of reset. Both wrap at 2^64.
//  - Shadow x10 updated on every commit with wvalid && wa==10.
// CONFIGURATION
//  COMMIT_TRAP_EN defined:
//   - A commit with instr==32'h0005006b pulses trap_valid for that cycle and sets halted.
//   - trap_code = shadow x10[2:0], with same-cycle write to x10 taken into account.
//   - Entries behind the halt remain queued; commit_valid is forced 0 until reset.
//  Not defined: trap_valid=0, trap_code=0; halt instr retires as an ordinary instruction.
// STRUCTURE
//  pipes package: retire_rec_t {pc,instr,regwrite,dst,result,is_mem,addr}; constant HALT_INSTR=32'h0005006b.
//  Sub-module retire_lookup: combinational youngest-first priority match over DEPTH entries.
//  Storage, pointers and counters stay in retire_queue.
// TESTING
//  1 Reset mid-stream with 3 entries queued -> next cycle count=0, commit_valid=0, instr_cnt=0, in_ready=1.
//  2 Enqueue 4 (DEPTH=4) with drain_en=0 -> in_ready=0.
//    Raise drain_en -> 4 commits on 4 consecutive cycles, pcs in order; instr_cnt=4.
//  3 Enqueue x5=1 then x5=2 and hold drain_en=0. Set lk_addr=5 -> lk_hit=1, lk_data=2.
//    Set lk_addr=0 -> lk_hit=0.
//  4 Store with addr=64'h4000_0000 -> commit_skip=1. Addr=64'h8000_0000 -> commit_skip=0.
//    Write to x0 -> commit_valid=1, wvalid=0.
//  5 Full queue with drain_en=1 and in_valid=1 -> no enqueue that cycle. Next cycle enqueue accepted.
//    Wrap through 10 records: commit order equals enqueue order.
//  6 With COMMIT_TRAP_EN: commit x10=0, then 0x0005006b -> trap_valid=1, trap_code=0.
//    Following entry never commits; in_ready=0.

Source files
------------

// File: rtl/retire_queue_pkg.sv
// Shared types and constants for the retire queue.
// The record stores pc, result and addr at the full 64-bit width; the queue
// zero-extends narrower XLEN values on entry and slices them on exit.
package retire_queue_pkg;

   localparam int unsigned REC_XLEN   = 64;
   localparam logic [31:0] HALT_INSTR = 32'h0005_006b;
   localparam logic [4:0]  X10_REG    = 5'd10;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] instr;
      logic        regwrite;
      logic [4:0]  dst;
      logic [63:0] result;
      logic        is_mem;
      logic [63:0] addr;
   } retire_rec_t;

   // A memory access whose selected address bit is clear targets MMIO space.
   function automatic logic rec_is_mmio(input retire_rec_t r, input int unsigned mmio_bit);
      return r.is_mem && (r.addr[mmio_bit] == 1'b0);
   endfunction

endpackage

// File: rtl/retire_lookup.sv
// Forwarding lookup over the queued retire records.
// Entries are walked from oldest to youngest, so a later match overrides an
// earlier one and the youngest writer of lk_addr wins. x0 never hits.
module retire_lookup
   import retire_queue_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned PW    = 2
) (
   input  retire_rec_t [DEPTH-1:0] ents,
   input  logic [PW-1:0]           head,
   input  logic [PW:0]             count,
   input  logic [4:0]              lk_addr,
   output logic                    lk_hit,
   output logic [63:0]             lk_data
);

   logic [PW-1:0] slot;

   // Youngest-first priority match across the valid window head..head+count-1.
   always_comb begin
      lk_hit  = 1'b0;
      lk_data = 64'd0;
      slot    = head;
      for (int i = 0; i < DEPTH; i++) begin
         slot = head + PW'(i);
         if (((PW+1)'(i) < count) && (lk_addr != 5'd0) &&
             ents[slot].regwrite && (ents[slot].dst == lk_addr)) begin
            lk_hit  = 1'b1;
            lk_data = ents[slot].result;
         end else begin
            lk_hit  = lk_hit;
            lk_data = lk_data;
         end
      end
   end

endmodule

// File: rtl/retire_queue.sv
// In-order retire buffer between the memory stage and architectural commit.
// Buffers up to DEPTH completed instructions and drains one per cycle into the
// regfile write port and commit trace. It also serves forwarding lookups and
// keeps retire/cycle counters.
// Optional feature macro: COMMIT_TRAP_EN (halt-trap detection and queue freeze).
module retire_queue
   import retire_queue_pkg::*;
#(
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned XLEN     = 64,
   parameter int unsigned MMIO_BIT = 31
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] in_pc,
   input  logic [31:0]     in_instr,
   input  logic            in_regwrite,
   input  logic [4:0]      in_dst,
   input  logic [XLEN-1:0] in_result,
   input  logic            in_is_mem,
   input  logic [XLEN-1:0] in_addr,
   input  logic            drain_en,
   output logic            wvalid,
   output logic [4:0]      wa,
   output logic [XLEN-1:0] wd,
   output logic            commit_valid,
   output logic [XLEN-1:0] commit_pc,
   output logic [31:0]     commit_instr,
   output logic            commit_skip,
   output logic            commit_wen,
   output logic [7:0]      commit_wdest,
   output logic [XLEN-1:0] commit_wdata,
   input  logic [4:0]      lk_addr,
   output logic            lk_hit,
   output logic [XLEN-1:0] lk_data,
   output logic [63:0]     instr_cnt,
   output logic [63:0]     cycle_cnt,
   output logic            trap_valid,
   output logic [2:0]      trap_code
);

   localparam int unsigned PW   = $clog2(DEPTH);
   localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

   retire_rec_t [DEPTH-1:0] mem_q, mem_d;
   logic [PW-1:0] head_q, head_d, tail_q, tail_d;
   logic [PW:0]   count_q, count_d;
   logic          halted_q, halted_d;
   logic [63:0]   instr_cnt_q, instr_cnt_d, cycle_cnt_q, cycle_cnt_d;
   retire_rec_t   head_rec, new_rec;
   logic          push, pop, nonempty;
   logic [63:0]   lk_data_full;

   // Handshake, pop decision and the record offered at the input.
   always_comb begin
      nonempty        = (count_q != (PW+1)'(0));
      in_ready        = (count_q != FULL) && !halted_q;
      push            = in_valid && in_ready;
      pop             = nonempty && drain_en && !halted_q;
      head_rec        = mem_q[head_q];
      new_rec         = '0;
      new_rec.pc      = REC_XLEN'(in_pc);
      new_rec.instr   = in_instr;
      new_rec.regwrite= in_regwrite;
      new_rec.dst     = in_dst;
      new_rec.result  = REC_XLEN'(in_result);
      new_rec.is_mem  = in_is_mem;
      new_rec.addr    = REC_XLEN'(in_addr);
   end

   // Commit trace and regfile write port, driven straight from the head entry.
   always_comb begin
      commit_valid = pop;
      commit_pc    = '0;
      commit_instr = 32'd0;
      commit_skip  = 1'b0;
      commit_wen   = 1'b0;
      commit_wdest = 8'd0;
      commit_wdata = '0;
      wvalid       = 1'b0;
      wa           = 5'd0;
      wd           = '0;
      if (nonempty) begin
         commit_pc    = head_rec.pc[XLEN-1:0];
         commit_instr = head_rec.instr;
         commit_skip  = rec_is_mmio(head_rec, MMIO_BIT);
         commit_wen   = head_rec.regwrite;
         commit_wdest = {3'b000, head_rec.dst};
         commit_wdata = head_rec.result[XLEN-1:0];
         wvalid       = pop && head_rec.regwrite && (head_rec.dst != 5'd0);
         wa           = head_rec.dst;
         wd           = head_rec.result[XLEN-1:0];
      end else begin
         commit_valid = 1'b0;
      end
   end

`ifdef COMMIT_TRAP_EN
   logic [2:0] x10_q, x10_d;
   logic       is_halt;

   // Halt detection. The reported code includes an x10 write retiring in the same cycle.
   always_comb begin
      is_halt = pop && (head_rec.instr == HALT_INSTR);
      x10_d   = x10_q;
      if (wvalid && (wa == X10_REG)) begin
         x10_d = wd[2:0];
      end else begin
         x10_d = x10_q;
      end
      trap_valid = is_halt;
      trap_code  = is_halt ? x10_d : 3'd0;
      halted_d   = halted_q | is_halt;
   end

   // Shadow copy of the low bits of x10 for the trap code.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         x10_q <= 3'd0;
      end else begin
         x10_q <= x10_d;
      end
   end
`else
   // Trap feature absent: halt retires as an ordinary instruction.
   always_comb begin
      trap_valid = 1'b0;
      trap_code  = 3'd0;
      halted_d   = halted_q;
   end
`endif

   // Next-state for storage, pointers and counters.
   always_comb begin
      mem_d       = mem_q;
      head_d      = head_q;
      tail_d      = tail_q;
      count_d     = count_q;
      if (push) begin
         mem_d[tail_q] = new_rec;
         tail_d        = tail_q + PW'(1);
      end else begin
         tail_d = tail_q;
      end
      if (pop) begin
         head_d = head_q + PW'(1);
      end else begin
         head_d = head_q;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + (PW+1)'(1);
         2'b01:   count_d = count_q - (PW+1)'(1);
         default: count_d = count_q;
      endcase
      instr_cnt_d = instr_cnt_q + (pop ? 64'd1 : 64'd0);
      cycle_cnt_d = cycle_cnt_q + 64'd1;
   end

   // State registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_q       <= '0;
         head_q      <= '0;
         tail_q      <= '0;
         count_q     <= '0;
         halted_q    <= 1'b0;
         instr_cnt_q <= 64'd0;
         cycle_cnt_q <= 64'd0;
      end else begin
         mem_q       <= mem_d;
         head_q      <= head_d;
         tail_q      <= tail_d;
         count_q     <= count_d;
         halted_q    <= halted_d;
         instr_cnt_q <= instr_cnt_d;
         cycle_cnt_q <= cycle_cnt_d;
      end
   end

   assign instr_cnt = instr_cnt_q;
   assign cycle_cnt = cycle_cnt_q;
   assign lk_data   = lk_data_full[XLEN-1:0];

   retire_lookup #(
      .DEPTH (DEPTH),
      .PW    (PW)
   ) u_lookup (
      .ents    (mem_q),
      .head    (head_q),
      .count   (count_q),
      .lk_addr (lk_addr),
      .lk_hit  (lk_hit),
      .lk_data (lk_data_full)
   );

endmodule
